// File: rtl/usb_rx_bit_timer.sv
// usb_rx_bit_timer: USB 1.1 RX bit timing recovery, sampling and bit unstuffing.
module usb_rx_bit_timer #(
  parameter int CLKS_PER_BIT = 8,
  parameter int SAMPLE_PHASE = 3,
  parameter int MAX_ONES     = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rcving,
  input  logic       d_edge,
  input  logic       d_orig,
  output logic       shift_enable,
  output logic       byte_received,
  output logic       stuff_err,
  output logic [2:0] bit_cnt
);
  localparam int PW = $clog2(CLKS_PER_BIT);
  localparam int OW = $clog2(MAX_ONES + 1);
  typedef enum logic {IDLE, RUN} state_t;
  state_t        state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [OW-1:0] ones_q, ones_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic          se_q, se_d, br_q, br_d, err_q, err_d, stuffed;
  always_comb begin
    state_d   = state_q;
    phase_d   = '0;
    ones_d    = '0;
    bit_cnt_d = '0;
    se_d      = 1'b0;
    br_d      = 1'b0;
    err_d     = 1'b0;
    stuffed   = ones_q == OW'(MAX_ONES);
    if (state_q == IDLE) begin
      state_d = rcving ? RUN : IDLE;
      phase_d = rcving ? PW'(1) : '0;
    end else if (!rcving) begin
      state_d = IDLE;
    end else begin
      // an edge marks phase 0 in its own cycle, so the next cycle is phase 1
      phase_d   = d_edge ? PW'(1) : (phase_q == PW'(CLKS_PER_BIT - 1) ? '0 : phase_q + 1'b1);
      ones_d    = ones_q;
      bit_cnt_d = bit_cnt_q;
      br_d      = se_q && bit_cnt_q == 3'd0;
      if (phase_q == PW'(SAMPLE_PHASE)) begin
        se_d      = !stuffed;
        err_d     = stuffed && d_orig;
        ones_d    = (!stuffed && d_orig) ? ones_q + 1'b1 : '0;
        bit_cnt_d = stuffed ? bit_cnt_q : bit_cnt_q + 3'd1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      phase_q   <= '0;
      ones_q    <= '0;
      bit_cnt_q <= '0;
      se_q      <= 1'b0;
      br_q      <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      ones_q    <= ones_d;
      bit_cnt_q <= bit_cnt_d;
      se_q      <= se_d;
      br_q      <= br_d;
      err_q     <= err_d;
    end
  end
  assign shift_enable  = se_q;
  assign byte_received = br_q;
  assign stuff_err     = err_q;
  assign bit_cnt       = bit_cnt_q;
endmodule

// File: tb/tb_usb_rx_bit_timer.sv
// tb_usb_rx_bit_timer: directed and randomized checks against a bit-level reference model.
module tb_usb_rx_bit_timer;
  localparam int CPB = 8, SP = 3, MX = 6;
  logic clk = 1'b0, rst, rcving, d_edge, d_orig;
  logic shift_enable, byte_received, stuff_err;
  logic [2:0] bit_cnt;
  int errors = 0, checks = 0, cyc = 0;
  int m_anchor, m_ones, m_bits;
  bit m_run, m_pend;
  logic exp_se, exp_br, exp_err;
  logic [2:0] exp_bc;
  logic se_h [0:127];
  logic br_h [0:127];
  logic err_h [0:127];
  logic [2:0] bc_h [0:127];

  usb_rx_bit_timer #(.CLKS_PER_BIT(CPB), .SAMPLE_PHASE(SP), .MAX_ONES(MX)) dut (
    .clk(clk), .rst(rst), .rcving(rcving), .d_edge(d_edge), .d_orig(d_orig),
    .shift_enable(shift_enable), .byte_received(byte_received),
    .stuff_err(stuff_err), .bit_cnt(bit_cnt)
  );

  always #5 clk = ~clk;

  // Model: a bit is sampled when the cycles elapsed since the last timing anchor
  // (reception start or a resync edge) are SP modulo the bit period.
  task automatic tick(input logic r, input logic rc, input logic de, input logic dor);
    logic se, br, er;
    rst = r; rcving = rc; d_edge = de; d_orig = dor;
    @(posedge clk);
    se = 1'b0; br = 1'b0; er = 1'b0;
    if (r) begin
      m_run = 0; m_ones = 0; m_bits = 0; m_pend = 0;
    end else if (!m_run) begin
      if (rc) begin m_run = 1; m_anchor = cyc; end
      m_pend = 0;
    end else if (!rc) begin
      m_run = 0; m_ones = 0; m_bits = 0; m_pend = 0;
    end else begin
      br = m_pend;
      m_pend = 0;
      if ((cyc - m_anchor) % CPB == SP) begin
        if (m_ones < MX) begin
          se = 1'b1;
          m_ones = dor ? m_ones + 1 : 0;
          m_bits = (m_bits + 1) % 8;
          m_pend = (m_bits == 0);
        end else begin
          er = dor;
          m_ones = 0;
        end
      end
      if (de) m_anchor = cyc;
    end
    exp_se = se; exp_br = br; exp_err = er; exp_bc = 3'(m_bits);
    cyc++;
    #1;
  endtask

  task automatic go_idle();
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if ({shift_enable, byte_received, stuff_err, bit_cnt} !== 6'd0) begin
      errors++; $display("FAIL reset_state got %b%b%b/%0d required 000/0", shift_enable, byte_received, stuff_err, bit_cnt);
    end
    go_idle();
    for (int i = 0; i < 21; i++) tick(1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (bit_cnt !== 3'd3) begin errors++; $display("FAIL reset_pre_bits got %0d required 3", bit_cnt); end
    tick(1'b1, 1'b1, 1'b0, 1'b0);
    checks++;
    if ({shift_enable, byte_received, stuff_err, bit_cnt} !== 6'd0) begin
      errors++; $display("FAIL reset_mid_byte got %b%b%b/%0d required 000/0", shift_enable, byte_received, stuff_err, bit_cnt);
    end
    for (int i = 0; i < 12; i++) begin
      tick(1'b0, 1'b0, 1'b0, 1'b0);
      checks++;
      if ({shift_enable, byte_received, stuff_err, bit_cnt} !== 6'd0) begin
        errors++; $display("FAIL reset_idle_hold got %b%b%b/%0d required 000/0", shift_enable, byte_received, stuff_err, bit_cnt);
      end
    end
  endtask

  task automatic test_sample_timing();
    int nse, bad;
    go_idle();
    nse = 0; bad = 0;
    for (int i = 0; i < 70; i++) begin
      tick(1'b0, 1'b1, 1'b0, 1'b0);
      checks++;
      if ({shift_enable, byte_received, stuff_err} !== {exp_se, exp_br, exp_err} || (!exp_se && bit_cnt !== exp_bc)) begin
        errors++; $display("FAIL timing_model cyc=%0d got %b%b%b/%0d required %b%b%b/%0d", i + 1, shift_enable, byte_received, stuff_err, bit_cnt, exp_se, exp_br, exp_err, exp_bc);
      end
      se_h[i + 1] = shift_enable; br_h[i + 1] = byte_received; bc_h[i + 1] = bit_cnt;
      if (shift_enable === 1'b1) nse++;
      if (shift_enable !== ((i + 1) % 8 == 4)) bad++;
      if (byte_received !== (i + 1 == 61)) bad++;
    end
    checks++;
    if (nse != 9 || bad != 0) begin errors++; $display("FAIL timing_pulses got count=%0d misplaced=%0d required 9/0", nse, bad); end
    checks++;
    if (bc_h[62] !== 3'd0 || br_h[61] !== 1'b1) begin errors++; $display("FAIL timing_byte got bc=%0d br=%b required 0/1", bc_h[62], br_h[61]); end
  endtask

  task automatic test_resync();
    go_idle();
    for (int i = 0; i < 40; i++) begin
      tick(1'b0, 1'b1, i == 10, 1'b0);
      checks++;
      if ({shift_enable, byte_received, stuff_err} !== {exp_se, exp_br, exp_err} || (!exp_se && bit_cnt !== exp_bc)) begin
        errors++; $display("FAIL resync_model cyc=%0d got %b%b%b/%0d required %b%b%b/%0d", i + 1, shift_enable, byte_received, stuff_err, bit_cnt, exp_se, exp_br, exp_err, exp_bc);
      end
      se_h[i + 1] = shift_enable;
    end
    checks++;
    if ({se_h[4], se_h[12], se_h[14], se_h[20], se_h[22], se_h[30]} !== 6'b101011) begin
      errors++; $display("FAIL resync_spacing got se@4,12,14,20,22,30=%b%b%b%b%b%b required 101011", se_h[4], se_h[12], se_h[14], se_h[20], se_h[22], se_h[30]);
    end
  endtask

  task automatic test_unstuff();
    int nse;
    go_idle();
    nse = 0;
    for (int i = 0; i < 62; i++) begin
      tick(1'b0, 1'b1, 1'b0, i / 8 < 6);
      checks++;
      if ({shift_enable, byte_received, stuff_err} !== {exp_se, exp_br, exp_err} || (!exp_se && bit_cnt !== exp_bc)) begin
        errors++; $display("FAIL unstuff_model cyc=%0d got %b%b%b/%0d required %b%b%b/%0d", i + 1, shift_enable, byte_received, stuff_err, bit_cnt, exp_se, exp_br, exp_err, exp_bc);
      end
      se_h[i + 1] = shift_enable; bc_h[i + 1] = bit_cnt; err_h[i + 1] = stuff_err;
      if (i + 1 <= 56 && shift_enable === 1'b1) nse++;
    end
    checks++;
    if (nse != 6 || se_h[52] !== 1'b0 || err_h[52] !== 1'b0) begin
      errors++; $display("FAIL unstuff_drop got count=%0d se52=%b err52=%b required 6/0/0", nse, se_h[52], err_h[52]);
    end
    checks++;
    if (bc_h[58] !== 3'd6 || se_h[60] !== 1'b1) begin
      errors++; $display("FAIL unstuff_after got bc=%0d se60=%b required 6/1", bc_h[58], se_h[60]);
    end
  endtask

  task automatic test_stuff_err();
    int nse;
    go_idle();
    nse = 0;
    for (int i = 0; i < 102; i++) begin
      tick(1'b0, 1'b1, 1'b0, 1'b1);
      checks++;
      if ({shift_enable, byte_received, stuff_err} !== {exp_se, exp_br, exp_err} || (!exp_se && bit_cnt !== exp_bc)) begin
        errors++; $display("FAIL stufferr_model cyc=%0d got %b%b%b/%0d required %b%b%b/%0d", i + 1, shift_enable, byte_received, stuff_err, bit_cnt, exp_se, exp_br, exp_err, exp_bc);
      end
      if (i + 1 < 128) begin se_h[i + 1] = shift_enable; err_h[i + 1] = stuff_err; end
      if (i + 1 > 52 && shift_enable === 1'b1) nse++;
    end
    checks++;
    if (err_h[52] !== 1'b1 || se_h[52] !== 1'b0) begin
      errors++; $display("FAIL stufferr_pulse got err=%b se=%b required 1/0", err_h[52], se_h[52]);
    end
    checks++;
    if (nse != 6) begin errors++; $display("FAIL stufferr_recover got %0d shifts required 6", nse); end
  endtask

  task automatic test_rcving_drop();
    go_idle();
    for (int i = 0; i < 66; i++) begin
      tick(1'b0, i < 59, 1'b0, 1'b0);
      checks++;
      if ({shift_enable, byte_received, stuff_err} !== {exp_se, exp_br, exp_err} || (!exp_se && bit_cnt !== exp_bc)) begin
        errors++; $display("FAIL drop_model cyc=%0d got %b%b%b/%0d required %b%b%b/%0d", i + 1, shift_enable, byte_received, stuff_err, bit_cnt, exp_se, exp_br, exp_err, exp_bc);
      end
      se_h[i + 1] = shift_enable; br_h[i + 1] = byte_received; bc_h[i + 1] = bit_cnt;
    end
    checks++;
    if (bc_h[59] !== 3'd7 || se_h[60] !== 1'b0 || br_h[61] !== 1'b0 || bc_h[61] !== 3'd0) begin
      errors++; $display("FAIL drop_suppress got bc59=%0d se60=%b br61=%b bc61=%0d required 7/0/0/0", bc_h[59], se_h[60], br_h[61], bc_h[61]);
    end
  endtask

  task automatic test_random();
    logic r, rc, de, dor;
    go_idle();
    rc = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      r = $urandom_range(0, 499) == 0;
      if (!rc) rc = $urandom_range(0, 9) == 0;
      else rc = $urandom_range(0, 299) != 0;
      de = $urandom_range(0, 19) == 0;
      dor = $urandom_range(0, 9) < 8;
      tick(r, rc, de, dor);
      checks++;
      if ({shift_enable, byte_received, stuff_err} !== {exp_se, exp_br, exp_err} || (!exp_se && bit_cnt !== exp_bc)) begin
        errors++; $display("FAIL random_model i=%0d got %b%b%b/%0d required %b%b%b/%0d", i, shift_enable, byte_received, stuff_err, bit_cnt, exp_se, exp_br, exp_err, exp_bc);
      end
    end
  endtask

  initial begin
    rst = 1'b1; rcving = 1'b0; d_edge = 1'b0; d_orig = 1'b0;
    m_run = 0; m_pend = 0; m_ones = 0; m_bits = 0; m_anchor = 0;
    test_reset();
    test_sample_timing();
    test_resync();
    test_unstuff();
    test_stuff_err();
    test_rcving_drop();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
